// File: rtl/marl_pkg.sv
// marl_pkg: shared types and constants for the multi-agent round scheduler.
//   REW_W / ACT_W : default reward and action widths
//   reward_t      : one agent's reward
//   action_t      : one agent's action
//   sched_state_e : scheduler FSM states
package marl_pkg;
  localparam int REW_W = 16;
  localparam int ACT_W = 9;

  typedef logic [REW_W-1:0] reward_t;
  typedef logic [ACT_W-1:0] action_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    OUTPUT = 3'd4
  } sched_state_e;
endpackage

// File: rtl/marl_round_scheduler_done_edge_det.sv
// done_edge_det: registered rising-edge detector for one agent's done line.
//   clk  : system clock
//   rst  : synchronous active-low reset (clears the history bit)
//   d    : agent done level
//   rise : high in the cycle where d is 1 and was 0 on the previous edge
module done_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_prev;

  always_ff @(posedge clk) begin
    if (!rst) d_prev <= 1'b0;
    else      d_prev <= d;
  end

  assign rise = d & ~d_prev;
endmodule

// File: rtl/marl_round_scheduler.sv
// marl_round_scheduler: runs one multi-agent RL round. Takes a reward vector
// from the environment, hands each reward to its agent in index order over a
// v/r/d handshake, gathers the actions and offers the joint action back.
//   env_valid/env_ready/env_reward : reward vector handshake (IDLE only)
//   agt_v/agt_r                    : per-agent reward pulse and registered reward
//   agt_a/agt_d                    : per-agent action and done (rising edge)
//   act_valid/act_ready/act_joint  : joint action handshake
//   round_cnt                      : completed rounds (wraps)
//   busy                           : not in IDLE
//   to_flags                       : per-agent timeout flags
// Optional feature macro MARL_SCHED_TIMEOUT_EN: WAIT gives up after
// TIMEOUT_CYC cycles, zeroes that agent's action and sets its timeout flag.
module marl_round_scheduler #(
  parameter int N_AGENTS    = 2,
  parameter int REW_W       = marl_pkg::REW_W,
  parameter int ACT_W       = marl_pkg::ACT_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      env_valid,
  output logic                      env_ready,
  input  logic [N_AGENTS*REW_W-1:0] env_reward,
  output logic [N_AGENTS-1:0]       agt_v,
  output logic [N_AGENTS*REW_W-1:0] agt_r,
  input  logic [N_AGENTS*ACT_W-1:0] agt_a,
  input  logic [N_AGENTS-1:0]       agt_d,
  output logic                      act_valid,
  input  logic                      act_ready,
  output logic [N_AGENTS*ACT_W-1:0] act_joint,
  output logic [15:0]               round_cnt,
  output logic                      busy,
  output logic [N_AGENTS-1:0]       to_flags
);
  import marl_pkg::*;

  localparam int IDX_W = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_AGENTS - 1);

  sched_state_e state_q, state_d;
  logic [IDX_W-1:0] idx;

  logic [N_AGENTS-1:0][REW_W-1:0] rew_q;    // latched reward vector
  logic [N_AGENTS-1:0][REW_W-1:0] agt_r_q;
  logic [N_AGENTS-1:0][ACT_W-1:0] act_in;
  logic [N_AGENTS-1:0][ACT_W-1:0] joint_q;
  logic [N_AGENTS-1:0]            rise;
  logic                           hs, adv, tmo, to_hit;

  assign act_in    = agt_a;
  assign agt_r     = agt_r_q;
  assign act_joint = joint_q;
  assign busy      = (state_q != IDLE);
  // Gated by rst so the environment never sees ready while reset is held.
  assign env_ready = (state_q == IDLE) & rst;
  assign hs        = env_valid & env_ready;

  genvar g;
  generate
    for (g = 0; g < N_AGENTS; g++) begin : g_edge
      done_edge_det u_det (.clk(clk), .rst(rst), .d(agt_d[g]), .rise(rise[g]));
    end
  endgenerate

`ifdef MARL_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]     to_cnt;
  logic [N_AGENTS-1:0] to_q;

  // Counter is zeroed in ISSUE so the first WAIT cycle sees 0; the
  // TIMEOUT_CYC-th WAIT cycle without a done edge fires the timeout.
  assign to_hit   = (state_q == WAIT) && !rise[idx] &&
                    (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign to_flags = to_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
      to_q   <= '0;
    end else begin
      if (state_q == ISSUE)     to_cnt <= '0;
      else if (state_q == WAIT) to_cnt <= to_cnt + TO_W'(1);
      if (hs)       to_q      <= '0;
      else if (tmo) to_q[idx] <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign to_hit   = 1'b0;
  assign to_flags = '0;
`endif

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE:   if (hs) state_d = SETUP;
      SETUP:  state_d = ISSUE;
      ISSUE:  state_d = WAIT;
      WAIT: begin
        // Only the selected agent's edge counts; a level already high on
        // entry has no edge because the detector history tracks it.
        tmo = to_hit;
        if (rise[idx] || to_hit) begin
          adv     = 1'b1;
          state_d = (idx == LAST) ? OUTPUT : SETUP;
        end
      end
      OUTPUT: if (act_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx       <= '0;
      rew_q     <= '0;
      agt_r_q   <= '0;
      agt_v     <= '0;
      act_valid <= 1'b0;
      joint_q   <= '0;
      round_cnt <= '0;
    end else begin
      state_q <= state_d;
      agt_v   <= '0;                 // pulse lasts one cycle
      case (state_q)
        IDLE: if (hs) begin
          rew_q <= env_reward;
          idx   <= '0;
        end
        SETUP: agt_r_q[idx] <= rew_q[idx];
        ISSUE: agt_v[idx]   <= 1'b1;
        WAIT: if (adv) begin
          joint_q[idx] <= tmo ? '0 : act_in[idx];
          if (idx == LAST) act_valid <= 1'b1;
          else             idx       <= idx + IDX_W'(1);
        end
        OUTPUT: if (act_ready) begin
          act_valid <= 1'b0;
          round_cnt <= round_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_marl_round_scheduler.sv
// tb_marl_round_scheduler: directed bench for marl_round_scheduler with two
// agents. Agent behaviour is driven by hand; expected values are literals.
// With MARL_SCHED_TIMEOUT_EN defined, a timeout round (TIMEOUT_CYC=16) runs too.
module tb_marl_round_scheduler;
  localparam int N  = 2;
  localparam int RW = 16;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            env_valid;
  logic            env_ready;
  logic [N*RW-1:0] env_reward;
  logic [N-1:0]    agt_v;
  logic [N*RW-1:0] agt_r;
  logic [N*AW-1:0] agt_a;
  logic [N-1:0]    agt_d;
  logic            act_valid;
  logic            act_ready;
  logic [N*AW-1:0] act_joint;
  logic [15:0]     round_cnt;
  logic            busy;
  logic [N-1:0]    to_flags;

  int n_chk  = 0;
  int n_fail = 0;

  marl_round_scheduler #(.N_AGENTS(N), .REW_W(RW), .ACT_W(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .env_valid(env_valid), .env_ready(env_ready), .env_reward(env_reward),
    .agt_v(agt_v), .agt_r(agt_r), .agt_a(agt_a), .agt_d(agt_d),
    .act_valid(act_valid), .act_ready(act_ready), .act_joint(act_joint),
    .round_cnt(round_cnt), .busy(busy), .to_flags(to_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; env_valid = 1'b0; env_reward = '0;
    agt_a = '0; agt_d = '0; act_ready = 1'b0;

    // 1. reset
    repeat (5) tick();
    chk("rst_env_ready", 64'(env_ready), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_agt_v",     64'(agt_v),     64'd0);
    chk("rst_agt_r",     64'(agt_r),     64'd0);
    chk("rst_act_valid", 64'(act_valid), 64'd0);
    chk("rst_act_joint", 64'(act_joint), 64'd0);
    chk("rst_round_cnt", 64'(round_cnt), 64'd0);
    chk("rst_to_flags",  64'(to_flags),  64'd0);
    rst = 1'b1;
    tick();
    chk("rel_env_ready", 64'(env_ready), 64'd1);

    // 2. single round
    env_reward = {16'h7FFF, 16'h1234}; env_valid = 1'b1;
    tick();                                   // E0
    env_valid = 1'b0;
    chk("r1_busy",      64'(busy),      64'd1);
    chk("r1_env_ready", 64'(env_ready), 64'd0);
    chk("r1_r0_e0",     64'(agt_r),     64'd0);
    tick();                                   // E0+1
    chk("r1_r0_e1",     64'(agt_r[15:0]), 64'h1234);
    chk("r1_v_e1",      64'(agt_v),       64'd0);
    tick();                                   // E0+2
    chk("r1_v_e2",      64'(agt_v),       64'b01);
    tick();                                   // E0+3
    chk("r1_v_e3",      64'(agt_v),       64'd0);
    repeat (8) tick();
    agt_a[8:0] = 9'h0A5; agt_d[0] = 1'b1;
    tick();                                   // edge sampled at E0+12
    agt_d[0] = 1'b0;
    chk("r1_j0",        64'(act_joint[8:0]), 64'h0A5);
    chk("r1_av_mid",    64'(act_valid),      64'd0);
    tick();
    chk("r1_r1",        64'(agt_r[31:16]),   64'h7FFF);
    chk("r1_r0_hold",   64'(agt_r[15:0]),    64'h1234);
    tick();
    chk("r1_v1",        64'(agt_v),          64'b10);
    tick();
    chk("r1_v1_off",    64'(agt_v),          64'd0);
    repeat (8) tick();
    chk("r1_av_pre",    64'(act_valid),      64'd0);
    agt_a[17:9] = 9'h1FF; agt_d[1] = 1'b1;
    tick();
    agt_d[1] = 1'b0;
    chk("r1_av",        64'(act_valid),      64'd1);
    chk("r1_joint",     64'(act_joint),      64'h3FEA5);
    tick(); tick();
    chk("r1_av_hold",   64'(act_valid),      64'd1);
    act_ready = 1'b1;
    tick();
    chk("r1_av_done",   64'(act_valid),      64'd0);
    chk("r1_cnt",       64'(round_cnt),      64'd1);
    chk("r1_idle",      64'(busy),           64'd0);
    tick();                                   // act_ready in IDLE is ignored
    act_ready = 1'b0;
    chk("r1_cnt_idle",  64'(round_cnt),      64'd1);

    // 3. stray done from agent 1 while agent 0 waits
    env_reward = {16'h0002, 16'h0001}; env_valid = 1'b1;
    tick();
    env_valid = 1'b0;
    tick(); tick(); tick();                   // now in WAIT for agent 0
    agt_a[17:9] = 9'h055; agt_d[1] = 1'b1;
    tick();
    agt_d[1] = 1'b0;
    tick();
    chk("st_v",         64'(agt_v),          64'd0);
    chk("st_busy",      64'(busy),           64'd1);
    chk("st_j1_keep",   64'(act_joint[17:9]), 64'h1FF);
    agt_a[8:0] = 9'h100; agt_d[0] = 1'b1;
    tick();
    agt_d[0] = 1'b0;
    tick();
    chk("st_r1",        64'(agt_r[31:16]),   64'h0002);
    tick();
    chk("st_v1",        64'(agt_v),          64'b10);
    tick();
    chk("st_av",        64'(act_valid),      64'd0);
    chk("st_joint_mid", 64'(act_joint),      64'h3FF00);
    agt_a[17:9] = 9'h077; agt_d[1] = 1'b1;
    tick();
    agt_d[1] = 1'b0;
    chk("st_joint",     64'(act_joint),      64'h0EF00);

    // 4. backpressure, with env_valid offered and ignored
    env_valid = 1'b1; env_reward = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      chk("bp_av",    64'(act_valid), 64'd1);
      chk("bp_joint", 64'(act_joint), 64'h0EF00);
      chk("bp_ready", 64'(env_ready), 64'd0);
      tick();
    end
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0; env_valid = 1'b0;
    chk("bp_cnt",       64'(round_cnt),      64'd2);
    chk("bp_av_done",   64'(act_valid),      64'd0);
    chk("bp_idle",      64'(busy),           64'd0);

    // 5. reset during agent 1 WAIT
    env_reward = {16'h0B0B, 16'h0A0A}; env_valid = 1'b1;
    tick();
    env_valid = 1'b0;
    tick(); tick(); tick();
    agt_d[0] = 1'b1;
    tick();
    agt_d[0] = 1'b0;
    tick(); tick();
    chk("mr_v1",        64'(agt_v),          64'b10);
    tick();                                   // agent 1 WAIT
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_busy",      64'(busy),           64'd0);
    chk("mr_av",        64'(act_valid),      64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_v",    64'(agt_v),          64'd0);
      chk("mr_idle",    64'(busy),           64'd0);
    end

`ifdef MARL_SCHED_TIMEOUT_EN
    // 6. agent 0 never completes
    agt_a[8:0] = 9'h1AB;
    env_reward = {16'h00BB, 16'h00AA}; env_valid = 1'b1;
    tick();                                   // E0
    env_valid = 1'b0;
    tick(); tick();                           // E0+2
    chk("to_v0",        64'(agt_v),          64'b01);
    repeat (15) tick();                       // E0+17: 15 WAIT cycles
    chk("to_flag_pre",  64'(to_flags),       64'd0);
    tick();                                   // 16th WAIT cycle
    chk("to_flag",      64'(to_flags),       64'b01);
    chk("to_j0",        64'(act_joint[8:0]), 64'd0);
    tick(); tick();
    chk("to_v1",        64'(agt_v),          64'b10);
    tick();
    agt_a[17:9] = 9'h0CC; agt_d[1] = 1'b1;
    tick();
    agt_d[1] = 1'b0;
    chk("to_joint",     64'(act_joint),      64'h19800);
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    chk("to_cnt",       64'(round_cnt),      64'd1);
    chk("to_flag_keep", 64'(to_flags),       64'b01);
    env_valid = 1'b1;
    tick();
    env_valid = 1'b0;
    chk("to_flag_clr",  64'(to_flags),       64'd0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
